conv_frame_server: RTL and testbench
====================================

# conv_frame_server

Memory-side responder for the `conv2d` engine. It loads a frame from an input pixel stream and asserts the engine's `start`. It answers the engine's `ReadAddress` with pixel data and captures `WriteAddress`/`d_out` results. When the engine raises `ready`, it streams the result frame out. It replaces the behavioural image memory wrapped around `conv2d` with synthesizable, handshaked buffering.

## Interface
Parameters:
- `DATA_W`, 12, pixel width; matches `d_in`/`d_out`.
- `ADDR_W`, 17, address width; matches `ReadAddress`/`WriteAddress`.
- `DEPTH`, 25, pixels per frame (5x5 test image); must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `s_valid`  in  1  input pixel valid.
- `s_ready`  out  1  input pixel accepted when `s_valid & s_ready`.
- `s_data`  in  `DATA_W`  input pixel, raster order.
- `conv_start`  out  1  one-cycle start pulse to `conv2d.start`.
- `conv_raddr`  in  `ADDR_W`  from `conv2d.ReadAddress`.
- `conv_rdata`  out  `DATA_W`  to `conv2d.d_in`.
- `conv_waddr`  in  `ADDR_W`  from `conv2d.WriteAddress`.
- `conv_wdata`  in  `DATA_W`  from `conv2d.d_out`.
- `conv_ready`  in  1  from `conv2d.ready`; high means the frame is complete.
- `m_valid`  out  1  result pixel valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  `DATA_W`  result pixel, address order 0..DEPTH-1.
- `m_last`  out  1  high with the final result pixel.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Two arrays: `img_mem[DEPTH]` holds the source frame and `res_mem[DEPTH]` holds the results.
- FSM states: IDLE, LOAD, START, RUN, DRAIN.
- **IDLE:**
  - `s_ready` = 1.
  - The first accepted pixel is written to `img_mem[0]` and the FSM moves to LOAD with `cnt` = 1.
  - If `DEPTH` = 1, the FSM goes directly to START.
- **LOAD:**
  - `s_ready` = 1.
  - Each accepted pixel is written to `img_mem[cnt]` and `cnt` increments.
  - When the accepted pixel has `cnt` = DEPTH-1, the FSM moves to START.
- **START:** `conv_start` = 1 for exactly one cycle, then RUN.
- **RUN:**
  - `res_mem[conv_waddr] <= conv_wdata` every cycle; a repeated address is a harmless rewrite.
  - A write with `conv_waddr` ≥ DEPTH is dropped.
  - The FSM leaves RUN on the first cycle where `conv_ready` = 1 and `conv_ready_q` = 0 (rising edge). The write in that same cycle still lands. Then `cnt` = 0 and the FSM enters DRAIN.
  - A `conv_ready` that is already high on RUN entry does not end RUN; the block waits for a fresh rising edge.
- **DRAIN:**
  - `m_valid` = 1 and `m_data` = `res_mem[cnt]`.
  - On `m_valid & m_ready`, `cnt` increments.
  - `m_last` = (`cnt` == DEPTH-1).
  - The transfer with `m_last` returns the FSM to IDLE.
  - `m_data` and `m_last` hold stable while `m_valid & !m_ready`.
- **Read port:**
  - `conv_rdata` = `img_mem[conv_raddr]` if `conv_raddr` < DEPTH, else 0.
  - Valid in all states; content is meaningful only after LOAD.
- `s_ready` = 0 outside IDLE/LOAD; input is back-pressured during START, RUN and DRAIN.
- Arithmetic:
  - `cnt` is `ADDR_W` bits.
  - Address compares are unsigned at full `ADDR_W`; no truncation of the address to a smaller width.

## Timing
- Reset, with `rst` = 0 sampled at a clock edge:
  - State goes to IDLE, `cnt` = 0 and `conv_ready_q` = 0.
  - Outputs: `conv_start` = 0, `m_valid` = 0, `m_last` = 0, `busy` = 0, `s_ready` = 1 after release.
  - Memories are not cleared.
- Reset mid-operation aborts the frame in any state; no start pulse or output is produced.
- Load: DEPTH accepted beats. `conv_start` is asserted on the cycle after the last beat is accepted.
- Read latency:
  - Default: combinational, 0 cycles, matching the `conv2d` assumption `d_in = mem[ReadAddress]`.
- Results: the first `m_valid` appears 1 cycle after the `conv_ready` rising edge. Throughput is 1 pixel/cycle with `m_ready` held high.

## Configuration
- `CONV_FRAME_SERVER_REG_READ_EN`:
  - **Defined:** `conv_rdata` is registered (1-cycle latency, block-RAM inference) and reset to 0. `conv2d` must then be built for 1-cycle read latency.
  - **Undefined:** combinational read as above.

## Structure
- Shared package `conv_pkg` holds:
  - `DATA_W` and `ADDR_W` defaults.
  - The `frame_state_t` enum {IDLE, LOAD, START, RUN, DRAIN}.
  - The `FRAME_DEPTH_TEST` = 25 constant.
- One natural sub-module: `frame_ram` (single write port, single read port; async read, or sync read under the macro), instantiated twice for `img_mem` and `res_mem`.
- The FSM and counters live in the top.

## Test plan
- **Load and start:** stream 25 pixels 0..24 with `s_valid` held high -> `s_ready` drops after beat 25; a single-cycle `conv_start` on the next cycle; `busy` = 1.
- **Read port:** in RUN, set `conv_raddr` = 7 -> `conv_rdata` = 7 the same cycle. Set `conv_raddr` = 30 -> `conv_rdata` = 0.
- **Capture and drain:**
  - Drive writes addr k ↦ data 100+k for k = 0..24, then raise `conv_ready`.
  - Expect the output stream 100..124, with `m_last` only on 124, and a return to IDLE with `busy` = 0.
- **Back-pressure:** toggle `m_ready` 1-0-1 during DRAIN -> no lost or duplicated pixels, and `m_data` stable while stalled.
- **Boundary:** a write to addr 25 with data 0xFFF is ignored (drained sequence unchanged). `conv_ready` high on RUN entry does not end RUN until it goes low then high.
- **Reset mid-RUN:** `rst` = 0 for one cycle -> IDLE with `m_valid` = 0 and `busy` = 0. A fresh 25-pixel load then proceeds normally.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv2d frame server.
// Optional feature macro: CONV_FRAME_SERVER_REG_READ_EN (registered engine read port).
package conv_pkg;

    localparam int DATA_W_DEF       = 12;
    localparam int ADDR_W_DEF       = 17;
    localparam int FRAME_DEPTH_TEST = 25;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DRAIN
    } frame_state_t;

endpackage

// File: rtl/frame_ram.sv
// Single-write, single-read frame buffer; out-of-range writes drop, reads return 0.
// REG_RD selects a registered read port (reset to 0) instead of an async one.
module frame_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 25,
    parameter bit REG_RD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_word;

    assign wr_ok   = we && ({1'b0, waddr} < DEPTH_A);
    assign rd_ok   = {1'b0, raddr} < DEPTH_A;
    assign rd_word = rd_ok ? mem_q[raddr[IW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[waddr[IW-1:0]] <= wdata;
        end
    end

    generate
        if (REG_RD) begin : g_reg
            logic [DATA_W-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rd_word;
                end
            end
            assign rdata = rdata_q;
        end else begin : g_comb
            logic unused_rst;
            assign unused_rst = rst;
            assign rdata      = rd_word;
        end
    endgenerate

endmodule

// File: rtl/conv_frame_server.sv
// Frame load / conv2d memory responder / result drain for the conv2d engine.
// Define CONV_FRAME_SERVER_REG_READ_EN for a registered conv_rdata port.
module conv_frame_server
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = FRAME_DEPTH_TEST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              conv_start,
    input  logic [ADDR_W-1:0] conv_raddr,
    output logic [DATA_W-1:0] conv_rdata,
    input  logic [ADDR_W-1:0] conv_waddr,
    input  logic [DATA_W-1:0] conv_wdata,
    input  logic              conv_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
);

`ifdef CONV_FRAME_SERVER_REG_READ_EN
    localparam bit IMG_REG_RD = 1'b1;
`else
    localparam bit IMG_REG_RD = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    frame_state_t      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rdy_q;
    logic              img_we;
    logic              res_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= conv_ready;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s_ready    = 1'b0;
        conv_start = 1'b0;
        m_valid    = 1'b0;
        img_we     = 1'b0;
        res_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    img_we  = 1'b1;
                    cnt_d   = ADDR_W'(1);
                    state_d = (DEPTH == 1) ? START : LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    img_we = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            START: begin
                conv_start = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                res_we = 1'b1;
                // Only a fresh rising edge of ready ends the frame.
                if (conv_ready && !rdy_q) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign m_last = (state_q == DRAIN) && (cnt_q == LAST);
    assign busy   = (state_q != IDLE);

    frame_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .REG_RD (IMG_REG_RD)
    ) u_img_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (img_we),
        .waddr (cnt_q),
        .wdata (s_data),
        .raddr (conv_raddr),
        .rdata (conv_rdata)
    );

    frame_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .REG_RD (1'b0)
    ) u_res_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (res_we),
        .waddr (conv_waddr),
        .wdata (conv_wdata),
        .raddr (cnt_q),
        .rdata (m_data)
    );

endmodule

// File: tb/tb_conv_frame_server.sv
// Randomized scoreboard bench for conv_frame_server against a frame-level model.
module tb_conv_frame_server;

    localparam int D = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic        conv_start;
    logic [16:0] conv_raddr = '0;
    logic [11:0] conv_rdata;
    logic [16:0] conv_waddr = 17'd25;
    logic [11:0] conv_wdata = '0;
    logic        conv_ready = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [11:0] m_data;
    logic        m_last;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    logic [11:0] img_m [D];
    logic [11:0] res_m [D];
    logic [12:0] exp_q [$];

    logic        stall_q = 1'b0;
    logic [11:0] held_d;
    logic        held_l;
    logic [12:0] mon_e;

    always #5 clk = ~clk;

    conv_frame_server dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .conv_start (conv_start),
        .conv_raddr (conv_raddr),
        .conv_rdata (conv_rdata),
        .conv_waddr (conv_waddr),
        .conv_wdata (conv_wdata),
        .conv_ready (conv_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted result beat.
    always @(negedge clk) begin
        if (rst) begin
            if (stall_q && m_valid) begin
                chk("stall_data", m_data, held_d);
                chk("stall_last", m_last, held_l);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0h expected no beat", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("m_data", m_data, mon_e[11:0]);
                    chk("m_last", m_last, mon_e[12]);
                end
            end
            stall_q = m_valid && !m_ready;
            held_d  = m_data;
            held_l  = m_last;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input bit seq, input bit gaps);
        int n = 0;
        while (n < D) begin
            s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = seq ? 12'(n) : 12'($urandom_range(0, 4095));
            @(negedge clk);
            chk("s_ready_load", s_ready, 1);
            if (s_valid) begin
                img_m[n] = s_data;
                n++;
            end
            step();
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("start_pulse", conv_start, 1);
        chk("s_ready_start", s_ready, 0);
        chk("busy_start", busy, 1);
        step();
        @(negedge clk);
        chk("start_single", conv_start, 0);
        step();
    endtask

    task automatic rd(input int a);
        conv_raddr = 17'(a);
        @(negedge clk);
        chk("rdata", conv_rdata, (a < D) ? 32'(img_m[a]) : 32'd0);
        step();
    endtask

    task automatic wr(input int a, input logic [11:0] d);
        conv_waddr = 17'(a);
        conv_wdata = d;
        if (a < D) res_m[a] = d;
        step();
        conv_waddr = 17'd25;
    endtask

    task automatic edge_wr(input int a, input logic [11:0] d);
        conv_ready = 1'b1;
        conv_waddr = 17'(a);
        conv_wdata = d;
        if (a < D) res_m[a] = d;
        for (int k = 0; k < D; k++) exp_q.push_back({(k == D - 1), res_m[k]});
        step();
        conv_ready = 1'b0;
        conv_waddr = 17'd25;
        @(negedge clk);
        chk("first_valid", m_valid, 1);
        chk("busy_drain", busy, 1);
        step();
    endtask

    task automatic drain(input bit rnd);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : (i != 2);
            step();
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("drain_idle", busy, 0);
        chk("drain_mvalid", m_valid, 0);
        chk("drain_sready", s_ready, 1);
        chk("queue_empty", exp_q.size(), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_start", conv_start, 0);
        chk("rst_mlast", m_last, 0);
        step();

        // Frame A: ramp pixels, directed writes, 1-0-1 stall.
        load_frame(1'b1, 1'b0);
        rd(7);
        rd(30);
        for (int i = 0; i < 4; i++) rd($urandom_range(0, 40));
        for (int k = 0; k < D - 1; k++) wr(k, 12'(100 + k));
        wr(25, 12'hFFF);
        edge_wr(24, 12'd124);
        drain(1'b0);

        // Frame B: ready already high on RUN entry.
        conv_ready = 1'b1;
        load_frame(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("run_hold_mvalid", m_valid, 0);
            chk("run_hold_busy", busy, 1);
            step();
        end
        for (int k = 0; k < D; k++) wr(k, 12'($urandom_range(0, 4095)));
        for (int i = 0; i < 5; i++) wr($urandom_range(0, 40), 12'($urandom_range(0, 4095)));
        conv_ready = 1'b0;
        step();
        edge_wr($urandom_range(0, 30), 12'($urandom_range(0, 4095)));
        drain(1'b1);

        // Frame C: reset in the middle of RUN.
        load_frame(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) wr($urandom_range(0, 24), 12'($urandom_range(0, 4095)));
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mvalid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sready", s_ready, 1);
        chk("midrst_start", conv_start, 0);
        step();

        // Frame D: fresh frame after the abort.
        load_frame(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) rd($urandom_range(0, 35));
        for (int k = 0; k < D; k++) wr(k, 12'($urandom_range(0, 4095)));
        for (int i = 0; i < 6; i++) wr($urandom_range(0, 40), 12'($urandom_range(0, 4095)));
        edge_wr($urandom_range(0, 24), 12'($urandom_range(0, 4095)));
        drain(1'b1);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
